// File: rtl/register_file_sb.sv
// Multi-ported register file with byte-masked writes and a per-register busy
// scoreboard used to track outstanding writes to each register.
module register_file_sb #(
  parameter int unsigned WORDSIZE     = 64,
  parameter int unsigned SIZE         = 32,
  parameter int unsigned ADDRSIZE     = 5,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned ZERO_REG     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    write_en,
  input  logic [ADDRSIZE-1:0]     write_addr,
  input  logic [WORDSIZE-1:0]     write_data,
  input  logic [WORDSIZE/8-1:0]   write_mask,
  input  logic [ADDRSIZE-1:0]     addr_a,
  input  logic [ADDRSIZE-1:0]     addr_b,
  output logic [WORDSIZE-1:0]     data_a,
  output logic [WORDSIZE-1:0]     data_b,
  input  logic                    reserve_en,
  input  logic [ADDRSIZE-1:0]     reserve_addr,
  output logic                    reserve_ok,
  output logic                    busy_a,
  output logic                    busy_b,
  output logic [ADDRSIZE:0]       busy_count
);

  localparam int unsigned NBYTES = WORDSIZE / 8;
  localparam int unsigned CW     = ADDRSIZE + 1;

  function automatic logic addr_valid(input logic [ADDRSIZE-1:0] a);
    return 32'(a) < SIZE;
  endfunction

  // A "live" register is one that can be written and reads back real data.
  function automatic logic addr_live(input logic [ADDRSIZE-1:0] a);
    return addr_valid(a) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [WORDSIZE-1:0] regs_q [SIZE];
  logic [WORDSIZE-1:0] regs_d [SIZE];
  logic [SIZE-1:0]     busy_q, busy_d;
  logic [CW-1:0]       busy_count_q, busy_count_d;

  logic                wr_ok_c;
  logic [WORDSIZE-1:0] old_word_c, new_word_c;

  // Byte-merge the incoming write; regs_d is the post-write view of the file.
  always_comb begin
    wr_ok_c    = rst_n && write_en && addr_live(write_addr);
    old_word_c = '0;
    if (addr_valid(write_addr)) old_word_c = regs_q[write_addr];
    new_word_c = old_word_c;
    for (int i = 0; i < NBYTES; i++) begin
      if (write_mask[i]) new_word_c[8*i +: 8] = write_data[8*i +: 8];
    end
    regs_d = regs_q;
    if (wr_ok_c) regs_d[write_addr] = new_word_c;
  end

  // A reservation of a busy register is allowed only when it is being written this cycle.
  always_comb begin
    reserve_ok = rst_n && reserve_en && addr_live(reserve_addr) &&
                 (!busy_q[reserve_addr] || (write_en && (write_addr == reserve_addr)));
    busy_a = addr_valid(addr_a) && busy_q[addr_a] && !(write_en && (write_addr == addr_a));
    busy_b = addr_valid(addr_b) && busy_q[addr_b] && !(write_en && (write_addr == addr_b));
  end

  logic inc_c, dec_c;

  // Write clears before reserve sets, so reserve wins on a same-register collision.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok_c)    busy_d[write_addr]   = 1'b0;
    if (reserve_ok) busy_d[reserve_addr] = 1'b1;
    inc_c = reserve_ok && !busy_q[reserve_addr];
    dec_c = wr_ok_c && busy_q[write_addr] &&
            !(reserve_ok && (reserve_addr == write_addr));
    busy_count_d = busy_count_q + CW'(inc_c) - CW'(dec_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) regs_q[i] <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

  generate
    if (READ_LATENCY == 0) begin : g_comb_read
      // Reading regs_d gives write-through bypass for free.
      always_comb begin
        data_a = '0;
        data_b = '0;
        if (addr_live(addr_a)) data_a = regs_d[addr_a];
        if (addr_live(addr_b)) data_b = regs_d[addr_b];
      end
    end else begin : g_reg_read
      logic [WORDSIZE-1:0] data_a_q, data_b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_a_q <= '0;
          data_b_q <= '0;
        end else begin
          data_a_q <= addr_live(addr_a) ? regs_d[addr_a] : '0;
          data_b_q <= addr_live(addr_b) ? regs_d[addr_b] : '0;
        end
      end

      assign data_a = data_a_q;
      assign data_b = data_b_q;
    end
  endgenerate

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: one combinational-read and one registered-read
// instance share stimulus; SIZE=24 so out-of-range addresses exist.
module tb_register_file_sb;

  localparam int unsigned W  = 64;
  localparam int unsigned N  = 24;
  localparam int unsigned AW = 5;
  localparam int unsigned NV = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [W-1:0]  write_data;
  logic [W/8-1:0] write_mask;
  logic [AW-1:0] addr_a, addr_b;
  logic          reserve_en;
  logic [AW-1:0] reserve_addr;

  logic [W-1:0]  d0_a, d0_b, d1_a, d1_b;
  logic          rok0, rok1, ba0, bb0, ba1, bb1;
  logic [AW:0]   cnt0, cnt1;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  register_file_sb #(.WORDSIZE(W), .SIZE(N), .ADDRSIZE(AW), .READ_LATENCY(0), .ZERO_REG(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .write_mask(write_mask), .addr_a(addr_a), .addr_b(addr_b),
    .data_a(d0_a), .data_b(d0_b), .reserve_en(reserve_en), .reserve_addr(reserve_addr),
    .reserve_ok(rok0), .busy_a(ba0), .busy_b(bb0), .busy_count(cnt0)
  );

  register_file_sb #(.WORDSIZE(W), .SIZE(N), .ADDRSIZE(AW), .READ_LATENCY(1), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .write_mask(write_mask), .addr_a(addr_a), .addr_b(addr_b),
    .data_a(d1_a), .data_b(d1_b), .reserve_en(reserve_en), .reserve_addr(reserve_addr),
    .reserve_ok(rok1), .busy_a(ba1), .busy_b(bb1), .busy_count(cnt1)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [7:0]    wm;
    logic [AW-1:0] aa;
    logic [AW-1:0] ab;
    logic          re;
    logic [AW-1:0] ra;
    logic [W-1:0]  ea;
    logic [W-1:0]  eb;
    logic          erok;
    logic          eba;
    logic          ebb;
    logic [AW:0]   ecnt;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic we, input int wa, input logic [W-1:0] wd,
                              input logic [7:0] wm, input int aa, input int ab,
                              input logic re, input int ra, input logic [W-1:0] ea,
                              input logic [W-1:0] eb, input logic erok, input logic eba,
                              input logic ebb, input int ecnt);
    vec_t v;
    v.we = we;  v.wa = AW'(wa); v.wd = wd; v.wm = wm;
    v.aa = AW'(aa); v.ab = AW'(ab); v.re = re; v.ra = AW'(ra);
    v.ea = ea; v.eb = eb; v.erok = erok; v.eba = eba; v.ebb = ebb;
    v.ecnt = (AW+1)'(ecnt);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    write_en = v.we; write_addr = v.wa; write_data = v.wd; write_mask = v.wm;
    addr_a = v.aa; addr_b = v.ab; reserve_en = v.re; reserve_addr = v.ra;
  endtask

  initial begin
    //              we wa  wd                      wm     aa  ab re ra  ea                      eb                      ok ba bb cnt
    vecs[0]  = mk(1, 13, 64'haabb,                8'hff, 13, 6,  0, 0,  64'haabb,               64'h0,                  0, 0, 0, 0);
    vecs[1]  = mk(0, 0,  64'h0,                   8'h00, 13, 4,  0, 0,  64'haabb,               64'h0,                  0, 0, 0, 0);
    vecs[2]  = mk(1, 4,  64'he45f_b21f,           8'h03, 4,  13, 0, 0,  64'hb21f,               64'haabb,               0, 0, 0, 0);
    vecs[3]  = mk(1, 0,  64'hdead_beef,           8'hff, 0,  4,  0, 0,  64'h0,                  64'hb21f,               0, 0, 0, 0);
    vecs[4]  = mk(0, 0,  64'h0,                   8'h00, 7,  0,  1, 7,  64'h0,                  64'h0,                  1, 0, 0, 0);
    vecs[5]  = mk(0, 0,  64'h0,                   8'h00, 7,  7,  1, 7,  64'h0,                  64'h0,                  0, 1, 1, 1);
    vecs[6]  = mk(1, 7,  64'h1122_3344_5566_7788, 8'hff, 7,  4,  1, 7,  64'h1122_3344_5566_7788, 64'hb21f,               1, 0, 0, 1);
    vecs[7]  = mk(0, 0,  64'h0,                   8'h00, 7,  13, 0, 0,  64'h1122_3344_5566_7788, 64'haabb,               0, 1, 0, 1);
    vecs[8]  = mk(0, 0,  64'h0,                   8'h00, 24, 0,  1, 0,  64'h0,                  64'h0,                  0, 0, 0, 1);
    vecs[9]  = mk(1, 24, 64'hffff,                8'hff, 24, 7,  1, 24, 64'h0,                  64'h1122_3344_5566_7788, 0, 0, 1, 1);
    vecs[10] = mk(1, 7,  64'hffff_ffff_ffff_ffff, 8'h00, 7,  13, 0, 0,  64'h1122_3344_5566_7788, 64'haabb,               0, 0, 0, 1);
    vecs[11] = mk(0, 0,  64'h0,                   8'h00, 7,  3,  0, 0,  64'h1122_3344_5566_7788, 64'h0,                  0, 0, 0, 0);
    vecs[12] = mk(1, 13, 64'hab00_0000_0000_0000, 8'h80, 13, 3,  1, 3,  64'hab00_0000_0000_aabb, 64'h0,                  1, 0, 0, 0);
    vecs[13] = mk(0, 0,  64'h0,                   8'h00, 3,  5,  1, 5,  64'h0,                  64'h0,                  1, 1, 0, 1);
    vecs[14] = mk(0, 0,  64'h0,                   8'h00, 5,  23, 1, 23, 64'h0,                  64'h0,                  1, 1, 0, 2);
    vecs[15] = mk(1, 5,  64'h55,                  8'h01, 5,  3,  1, 3,  64'h55,                 64'h0,                  0, 0, 1, 3);
    vecs[16] = mk(0, 0,  64'h0,                   8'h00, 23, 5,  0, 0,  64'h0,                  64'h55,                 0, 1, 0, 2);

    rst_n = 1'b0;
    drive(mk(0, 0, 64'h0, 8'h00, 13, 6, 0, 0, 64'h0, 64'h0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk("reset data_a comb", d0_a, 64'h0);
    chk("reset data_a reg", d1_a, 64'h0);
    chk("reset busy_count", W'(cnt0), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d comb data_a", i), d0_a, vecs[i].ea);
      chk($sformatf("v%0d comb data_b", i), d0_b, vecs[i].eb);
      chk($sformatf("v%0d reserve_ok", i), W'(rok0), W'(vecs[i].erok));
      chk($sformatf("v%0d reserve_ok reg", i), W'(rok1), W'(vecs[i].erok));
      chk($sformatf("v%0d busy_a", i), W'(ba0), W'(vecs[i].eba));
      chk($sformatf("v%0d busy_b", i), W'(bb0), W'(vecs[i].ebb));
      chk($sformatf("v%0d busy_count", i), W'(cnt0), W'(vecs[i].ecnt));
      chk($sformatf("v%0d busy_count reg", i), W'(cnt1), W'(vecs[i].ecnt));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d reg data_a", i), d1_a, vecs[i].ea);
      chk($sformatf("v%0d reg data_b", i), d1_b, vecs[i].eb);
    end

    // Async reset mid-cycle with a write and a reserve pending.
    chk("pre-reset busy_count", W'(cnt0), 64'd2);
    drive(mk(1, 13, 64'hffff, 8'hff, 13, 7, 1, 9, 64'h0, 64'h0, 0, 0, 0, 0));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst comb data_a", d0_a, 64'h0);
    chk("async rst comb data_b", d0_b, 64'h0);
    chk("async rst reg data_a", d1_a, 64'h0);
    chk("async rst reg data_b", d1_b, 64'h0);
    chk("async rst busy_count", W'(cnt0), 64'h0);
    chk("async rst busy_count reg", W'(cnt1), 64'h0);
    chk("async rst reserve_ok", W'(rok0), 64'h0);
    chk("async rst busy_b", W'(bb0), 64'h0);
    @(posedge clk);
    #1;
    chk("held rst busy_count", W'(cnt0), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(0, 0, 64'h0, 8'h00, 13, 9, 0, 0, 64'h0, 64'h0, 0, 0, 0, 0));
    #1;
    chk("post-rst write discarded", d0_a, 64'h0);
    chk("post-rst reserve discarded", W'(bb0), 64'h0);
    chk("post-rst busy_count", W'(cnt0), 64'h0);
    @(posedge clk);
    #1;
    chk("post-rst reg data_a", d1_a, 64'h0);

    // Normal operation resumes on the first edge after release.
    @(negedge clk);
    drive(mk(1, 9, 64'hcafe_1234, 8'h03, 9, 13, 1, 9, 64'h0, 64'h0, 0, 0, 0, 0));
    #1;
    chk("resume reserve_ok", W'(rok0), 64'h1);
    chk("resume comb data_a", d0_a, 64'h1234);
    @(posedge clk);
    #1;
    chk("resume reg data_a", d1_a, 64'h1234);
    chk("resume busy_count", W'(cnt0), 64'd1);
    chk("resume busy_a", W'(ba0), 64'h0);
    @(negedge clk);
    drive(mk(0, 0, 64'h0, 8'h00, 9, 13, 0, 0, 64'h0, 64'h0, 0, 0, 0, 0));
    #1;
    chk("resume busy_a held", W'(ba0), 64'h1);
    chk("resume busy_a held reg", W'(ba1), 64'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 SHALL have parameter WORDSIZE, default 64, data word width in bits, a multiple of 8.
REQ-002 SHALL have parameter SIZE, default 32, number of registers, at most 2^ADDRSIZE.
REQ-003 SHALL have parameter ADDRSIZE, default 5, register address width.
REQ-004 SHALL have parameter READ_LATENCY, default 0, read mode: 0 = combinational with bypass, 1 = registered.
REQ-005 SHALL have parameter ZERO_REG, default 1, where 1 = register 0 is hardwired to zero.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-008 SHALL have port write_en, input, 1, write strobe.
REQ-009 SHALL have port write_addr, input, ADDRSIZE, write register index.
REQ-010 SHALL have port write_data, input, WORDSIZE, write word.
REQ-011 SHALL have port write_mask, input, WORDSIZE/8, byte enables; bit i covers data bits [8i+7:8i].
REQ-012 SHALL have ports addr_a and addr_b, input, ADDRSIZE, read port indices.
REQ-013 SHALL have ports data_a and data_b, output, WORDSIZE, read port data.
REQ-014 SHALL have ports reserve_en (input, 1) and reserve_addr (input, ADDRSIZE), a scoreboard reservation request.
REQ-015 SHALL have port reserve_ok, output, 1, reservation accepted this cycle.
REQ-016 SHALL have ports busy_a and busy_b, output, 1, pending-write status of addr_a and addr_b.
REQ-017 SHALL have port busy_count, output, ADDRSIZE+1, number of registers currently busy.

Function
REQ-018 SHALL write on a clk edge when write_en=1, the address is valid and writable: masked bytes take write_data, unmasked bytes are retained.
REQ-019 SHALL treat an address as invalid when it is >= SIZE, and as not writable when it is 0 with ZERO_REG=1; such writes SHALL be ignored.
REQ-020 SHALL return 0 on any read of an invalid address or of register 0 when ZERO_REG=1.
REQ-021 SHALL, with READ_LATENCY=0, drive data_x combinationally; when a write in the same cycle targets addr_x, data_x SHALL be the merged post-write word (bypass).
REQ-022 SHALL, with READ_LATENCY=1, register data_x on each clk edge with the post-write value of addr_x, giving 1-cycle latency.
REQ-023 SHALL keep both read ports fully independent; addr_a=addr_b SHALL return identical data.
REQ-024 SHALL keep one busy bit per register; bits for register 0 (when ZERO_REG=1) and for invalid addresses SHALL always be 0.
REQ-025 SHALL compute reserve_ok combinationally as reserve_en AND reserve_addr valid and writable AND (busy[reserve_addr]=0 OR a same-cycle write_en targets reserve_addr).
REQ-026 SHALL set busy[reserve_addr] on a clk edge when reserve_ok=1; a rejected request SHALL change no state.
REQ-027 SHALL clear busy[write_addr] on any accepted write, whatever write_mask is.
REQ-028 SHALL, when a write and an accepted reserve target the same register in one cycle, perform the write and leave the busy bit at 1 (reserve wins).
REQ-029 SHALL drive busy_x = busy[addr_x] AND NOT (a same-cycle write_en to addr_x), combinationally in both modes.
REQ-030 SHALL update busy_count incrementally each edge: +1 for a set, -1 for a clear, net 0 when both act on the same register; it SHALL equal the popcount of the busy bits.

Reset
REQ-031 SHALL, while rst_n=0, immediately and asynchronously clear all registers, all busy bits, busy_count and (READ_LATENCY=1) data_a/data_b to 0.
REQ-032 SHALL discard any write or reserve coinciding with rst_n=0 and resume normal behaviour on the first clk edge after release.

Verification
REQ-033 SHALL cover: write 64'h0000_0000_0000_aabb to addr 13 with mask 8'hFF, then read addr_a=13 -> data_a=...aabb (same cycle when READ_LATENCY=0, next edge when READ_LATENCY=1); addr_b=6 -> 0.
REQ-034 SHALL cover: with reg 4 = 0, write 64'h0000_0000_e45f_b21f with mask 8'h03 -> reg 4 = 64'h0000_0000_0000_b21f; a write to addr 0 -> data_a=0 on a read of addr 0.
REQ-035 SHALL cover: reserve addr 7 -> reserve_ok=1, then busy_count=1 and busy_a=1 for addr_a=7; a second reserve of 7 -> reserve_ok=0 and busy_count stays 1.
REQ-036 SHALL cover: while reg 7 is busy, write to 7 and reserve 7 in the same cycle -> reserve_ok=1, new data stored, busy[7]=1, busy_count unchanged.
REQ-037 SHALL cover: reserve addrs 0 and SIZE (when SIZE<2^ADDRSIZE) -> reserve_ok=0; a read of addr SIZE -> 0.
REQ-038 SHALL cover: assert rst_n=0 between clk edges after several writes and reserves -> all reads 0, busy_count=0 before the next edge.
